// File: rtl/vend_pkg.sv
// vend_pkg: coin encodings, cent lookup helpers and the sequencer state
// enum shared by the vending controller files.
package vend_pkg;

  localparam int N_DENOM = 5;

  localparam logic [2:0] COIN_5C   = 3'd0;
  localparam logic [2:0] COIN_10C  = 3'd1;
  localparam logic [2:0] COIN_25C  = 3'd2;
  localparam logic [2:0] COIN_50C  = 3'd3;
  localparam logic [2:0] COIN_100C = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GO,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

  // Cent value of a coin code; 0 marks an invalid code.
  function automatic logic [6:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_5C:   coin_value = 7'd5;
      COIN_10C:  coin_value = 7'd10;
      COIN_25C:  coin_value = 7'd25;
      COIN_50C:  coin_value = 7'd50;
      COIN_100C: coin_value = 7'd100;
      default:   coin_value = 7'd0;
    endcase
  endfunction

  // One-hot denomination of a dispensed coin; all-zero for no/unknown coin.
  function automatic logic [N_DENOM-1:0] denom_onehot(input logic [6:0] cents);
    case (cents)
      7'd5:    denom_onehot = 5'b00001;
      7'd10:   denom_onehot = 5'b00010;
      7'd25:   denom_onehot = 5'b00100;
      7'd50:   denom_onehot = 5'b01000;
      7'd100:  denom_onehot = 5'b10000;
      default: denom_onehot = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// vend_controller_if: front-panel, coin-acceptor and change-dispenser
// signals of the vending controller. slave = controller side,
// master = the surrounding logic driving it.
interface vend_controller_if;
  logic       coin_valid;
  logic [2:0] coin_code;
  logic       select;
  logic [9:0] price;
  logic       refund;
  logic       disp_done;
  logic [6:0] change_dispensed;
  logic       go_signal;
  logic [9:0] change;
  logic [4:0] avail_coins;
  logic       low_nickels;
  logic [9:0] credit;
  logic       vend_item;
  logic       coin_reject;
  logic       insufficient;
  logic       short_change;
  logic       busy;

  modport slave (
    input  coin_valid, coin_code, select, price, refund, disp_done, change_dispensed,
    output go_signal, change, avail_coins, low_nickels, credit, vend_item,
           coin_reject, insufficient, short_change, busy
  );

  modport master (
    output coin_valid, coin_code, select, price, refund, disp_done, change_dispensed,
    input  go_signal, change, avail_coins, low_nickels, credit, vend_item,
           coin_reject, insufficient, short_change, busy
  );
endinterface

// File: rtl/vend_controller_coin_inventory.sv
// coin_inventory: one saturating up/down counter per denomination.
// Accepted coins count up (stick at all-ones), dispensed coins count
// down (stick at zero). Availability flags are combinational.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int CNT_W             = 8,
  parameter int INIT_COUNT        = 10,
  parameter int LOW_NICKEL_THRESH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DENOM-1:0] inc_i,
  input  logic [N_DENOM-1:0] dec_i,
  output logic [N_DENOM-1:0] avail_o,
  output logic               low_nickels_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COUNT);

  logic [CNT_W-1:0] cnt_q [N_DENOM];

  for (genvar i = 0; i < N_DENOM; i++) begin : g_cnt
    // Saturating count of coins of denomination i held in the machine.
    always_ff @(posedge clk) begin
      if (reset)
        cnt_q[i] <= CNT_INIT;
      else if (inc_i[i] && !dec_i[i] && cnt_q[i] != CNT_MAX)
        cnt_q[i] <= cnt_q[i] + 1'b1;
      else if (dec_i[i] && !inc_i[i] && cnt_q[i] != '0)
        cnt_q[i] <= cnt_q[i] - 1'b1;
    end
    assign avail_o[i] = (cnt_q[i] != '0);
  end

  assign low_nickels_o = ({24'd0, cnt_q[COIN_5C]} < 32'(LOW_NICKEL_THRESH));

endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin/credit/select sequencer driving change_dispenser
// through go/done. Optional macro REFUND_EN builds the refund path; when
// undefined the refund input is ignored.
module vend_controller
  import vend_pkg::*;
#(
  parameter int CNT_W             = 8,
  parameter int INIT_COUNT        = 10,
  parameter int LOW_NICKEL_THRESH = 4,
  parameter int MAX_CREDIT        = 1000
) (
  input logic              clk,
  input logic              reset,
  vend_controller_if.slave bus
);

  state_e             state_q;
  logic [9:0]         credit_q, change_q, paid_q;
  logic [1:0]         ack_cnt_q;
  logic               go_q, vend_q, reject_q, insuf_q, short_q;

  logic               in_idle, refund_take, select_take, coin_fits, coin_accept;
  logic [6:0]         coin_val, paid_val;
  logic [10:0]        credit_sum;
  logic [9:0]         paid_sum;
  logic [N_DENOM-1:0] inv_inc, inv_dec;

  // Arbitrate refund > select > coin in IDLE and decode inventory updates.
  always_comb begin
    in_idle    = (state_q == S_IDLE);
    coin_val   = coin_value(bus.coin_code);
    credit_sum = {1'b0, credit_q} + 11'(coin_val);
    coin_fits  = (coin_val != 7'd0) && (credit_sum <= 11'(MAX_CREDIT));
`ifdef REFUND_EN
    refund_take = in_idle && bus.refund && (credit_q != '0);
`else
    refund_take = 1'b0;
`endif
    select_take = in_idle && bus.select && !refund_take;
    coin_accept = in_idle && bus.coin_valid && !refund_take && !bus.select && coin_fits;
    inv_inc     = coin_accept ? (N_DENOM'(1) << bus.coin_code) : '0;
    inv_dec     = (state_q == S_WAIT_DONE) ? denom_onehot(bus.change_dispensed) : '0;
    paid_val    = (|inv_dec) ? bus.change_dispensed : 7'd0;
    paid_sum    = paid_q + 10'(paid_val);
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      credit_q  <= '0;
      change_q  <= '0;
      paid_q    <= '0;
      ack_cnt_q <= '0;
      go_q      <= 1'b0;
      vend_q    <= 1'b0;
      reject_q  <= 1'b0;
      insuf_q   <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      go_q     <= 1'b0;
      vend_q   <= 1'b0;
      insuf_q  <= 1'b0;
      // Any coin not accepted (busy, bad code, over ceiling, lost arbitration).
      reject_q <= bus.coin_valid && !coin_accept;
      unique case (state_q)
        S_IDLE: begin
          if (refund_take) begin
            change_q  <= credit_q;
            credit_q  <= '0;
            paid_q    <= '0;
            ack_cnt_q <= '0;
            go_q      <= 1'b1;
            state_q   <= S_GO;
          end else if (select_take) begin
            short_q <= 1'b0;
            if (credit_q >= bus.price) begin
              vend_q   <= 1'b1;
              credit_q <= '0;
              if (credit_q != bus.price) begin
                change_q  <= credit_q - bus.price;
                paid_q    <= '0;
                ack_cnt_q <= '0;
                go_q      <= 1'b1;
                state_q   <= S_GO;
              end
            end else begin
              insuf_q <= 1'b1;
            end
          end else if (coin_accept) begin
            credit_q <= credit_sum[9:0];
          end
        end
        S_GO: state_q <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          // Dispenser must drop done to acknowledge; 4 stuck cycles = nothing paid.
          if (!bus.disp_done) begin
            state_q <= S_WAIT_DONE;
          end else if (ack_cnt_q == 2'd3) begin
            short_q  <= 1'b1;
            change_q <= '0;
            state_q  <= S_IDLE;
          end else begin
            ack_cnt_q <= ack_cnt_q + 2'd1;
          end
        end
        S_WAIT_DONE: begin
          paid_q <= paid_sum;
          if (bus.disp_done) begin
            short_q  <= (paid_sum != change_q);
            change_q <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  coin_inventory #(
    .CNT_W            (CNT_W),
    .INIT_COUNT       (INIT_COUNT),
    .LOW_NICKEL_THRESH(LOW_NICKEL_THRESH)
  ) u_inv (
    .clk          (clk),
    .reset        (reset),
    .inc_i        (inv_inc),
    .dec_i        (inv_dec),
    .avail_o      (bus.avail_coins),
    .low_nickels_o(bus.low_nickels)
  );

  assign bus.go_signal    = go_q;
  assign bus.change       = change_q;
  assign bus.credit       = credit_q;
  assign bus.vend_item    = vend_q;
  assign bus.coin_reject  = reject_q;
  assign bus.insufficient = insuf_q;
  assign bus.short_change = short_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scenarios for vend_controller with
// hand-computed expectations. Inputs change 1ns after a rising edge and
// outputs are sampled there too.
module tb_vend_controller;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  vend_controller_if bus();

  vend_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset                = 1'b1;
    bus.coin_valid       = 1'b0;
    bus.coin_code        = 3'd0;
    bus.select           = 1'b0;
    bus.price            = 10'd0;
    bus.refund           = 1'b0;
    bus.disp_done        = 1'b0;
    bus.change_dispensed = 7'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic insert(input logic [2:0] code);
    bus.coin_valid = 1'b1;
    bus.coin_code  = code;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic select_price(input logic [9:0] p);
    bus.select = 1'b1;
    bus.price  = p;
    tick();
    bus.select = 1'b0;
  endtask

  task automatic pay(input logic [6:0] v, input int n);
    repeat (n) begin
      bus.change_dispensed = v;
      tick();
    end
    bus.change_dispensed = 7'd0;
  endtask

  task automatic finish_disp();
    bus.disp_done = 1'b1;
    tick();
    bus.disp_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.credit !== 10'd0) begin bad++; $display("FAIL rst_credit got=%0d want=0", bus.credit); end
    total++; if ({bus.go_signal, bus.vend_item, bus.coin_reject, bus.insufficient, bus.short_change, bus.busy} !== 6'b0) begin bad++; $display("FAIL rst_flags got=%b want=000000", {bus.go_signal, bus.vend_item, bus.coin_reject, bus.insufficient, bus.short_change, bus.busy}); end
    total++; if (bus.change !== 10'd0) begin bad++; $display("FAIL rst_change got=%0d want=0", bus.change); end
    total++; if (bus.avail_coins !== 5'b11111) begin bad++; $display("FAIL rst_avail got=%b want=11111", bus.avail_coins); end
    total++; if (bus.low_nickels !== 1'b0) begin bad++; $display("FAIL rst_low got=%b want=0", bus.low_nickels); end
  endtask

  task automatic test_basic_vend();
    do_reset();
    insert(3'd4);
    insert(3'd2);
    total++; if (bus.credit !== 10'd125) begin bad++; $display("FAIL vend_credit got=%0d want=125", bus.credit); end
    select_price(10'd75);
    total++; if (bus.vend_item !== 1'b1) begin bad++; $display("FAIL vend_pulse got=%b want=1", bus.vend_item); end
    total++; if (bus.go_signal !== 1'b1) begin bad++; $display("FAIL vend_go got=%b want=1", bus.go_signal); end
    total++; if (bus.change !== 10'd50) begin bad++; $display("FAIL vend_change got=%0d want=50", bus.change); end
    total++; if (bus.credit !== 10'd0 || bus.busy !== 1'b1) begin bad++; $display("FAIL vend_state credit=%0d busy=%b want 0/1", bus.credit, bus.busy); end
    tick();
    total++; if (bus.go_signal !== 1'b0 || bus.vend_item !== 1'b0) begin bad++; $display("FAIL vend_go_width go=%b vend=%b want 0/0", bus.go_signal, bus.vend_item); end
    total++; if (bus.change !== 10'd50) begin bad++; $display("FAIL vend_change_hold got=%0d want=50", bus.change); end
    tick();
    pay(7'd50, 1);
    finish_disp();
    total++; if (bus.short_change !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL vend_done short=%b busy=%b want 0/0", bus.short_change, bus.busy); end
    total++; if (bus.change !== 10'd0) begin bad++; $display("FAIL vend_change_clr got=%0d want=0", bus.change); end
    total++; if (dut.u_inv.cnt_q[4] !== 8'd11 || dut.u_inv.cnt_q[2] !== 8'd11 || dut.u_inv.cnt_q[3] !== 8'd9) begin bad++; $display("FAIL vend_inv got=%0d/%0d/%0d want 11/11/9", dut.u_inv.cnt_q[4], dut.u_inv.cnt_q[2], dut.u_inv.cnt_q[3]); end
  endtask

  task automatic test_credit_ceiling();
    do_reset();
    repeat (9) insert(3'd4);
    insert(3'd3);
    insert(3'd2);
    insert(3'd1);
    insert(3'd1);
    total++; if (bus.credit !== 10'd995) begin bad++; $display("FAIL ceil_credit got=%0d want=995", bus.credit); end
    insert(3'd1);
    total++; if (bus.coin_reject !== 1'b1) begin bad++; $display("FAIL ceil_reject got=%b want=1", bus.coin_reject); end
    total++; if (bus.credit !== 10'd995 || dut.u_inv.cnt_q[1] !== 8'd12) begin bad++; $display("FAIL ceil_hold credit=%0d dimes=%0d want 995/12", bus.credit, dut.u_inv.cnt_q[1]); end
    tick();
    total++; if (bus.coin_reject !== 1'b0) begin bad++; $display("FAIL ceil_reject_width got=%b want=0", bus.coin_reject); end
    insert(3'd0);
    total++; if (bus.credit !== 10'd1000 || bus.coin_reject !== 1'b0) begin bad++; $display("FAIL ceil_exact credit=%0d rej=%b want 1000/0", bus.credit, bus.coin_reject); end
    insert(3'd0);
    total++; if (bus.credit !== 10'd1000 || bus.coin_reject !== 1'b1) begin bad++; $display("FAIL ceil_over credit=%0d rej=%b want 1000/1", bus.credit, bus.coin_reject); end
    do_reset();
    insert(3'd5);
    total++; if (bus.credit !== 10'd0 || bus.coin_reject !== 1'b1) begin bad++; $display("FAIL bad_code credit=%0d rej=%b want 0/1", bus.credit, bus.coin_reject); end
  endtask

  task automatic test_insufficient();
    do_reset();
    insert(3'd3);
    select_price(10'd60);
    total++; if (bus.insufficient !== 1'b1) begin bad++; $display("FAIL insuf_pulse got=%b want=1", bus.insufficient); end
    total++; if (bus.credit !== 10'd50 || bus.go_signal !== 1'b0 || bus.vend_item !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL insuf_state credit=%0d go=%b vend=%b busy=%b want 50/0/0/0", bus.credit, bus.go_signal, bus.vend_item, bus.busy); end
    tick();
    total++; if (bus.insufficient !== 1'b0 || bus.go_signal !== 1'b0) begin bad++; $display("FAIL insuf_width insuf=%b go=%b want 0/0", bus.insufficient, bus.go_signal); end
  endtask

  task automatic test_short_change();
    do_reset();
    insert(3'd4);
    select_price(10'd95);
    total++; if (bus.change !== 10'd5) begin bad++; $display("FAIL drain_change got=%0d want=5", bus.change); end
    tick();
    tick();
    pay(7'd100, 11);
    pay(7'd50, 10);
    pay(7'd25, 10);
    pay(7'd10, 10);
    pay(7'd5, 8);
    finish_disp();
    total++; if (bus.avail_coins !== 5'b00001 || bus.low_nickels !== 1'b1) begin bad++; $display("FAIL drain_avail avail=%b low=%b want 00001/1", bus.avail_coins, bus.low_nickels); end
    total++; if (bus.short_change !== 1'b1) begin bad++; $display("FAIL drain_short got=%b want=1", bus.short_change); end
    insert(3'd4);
    total++; if (bus.avail_coins !== 5'b10001 || bus.short_change !== 1'b1) begin bad++; $display("FAIL short_sticky avail=%b short=%b want 10001/1", bus.avail_coins, bus.short_change); end
    select_price(10'd85);
    total++; if (bus.change !== 10'd15 || bus.short_change !== 1'b0 || bus.vend_item !== 1'b1) begin bad++; $display("FAIL short_start change=%0d short=%b vend=%b want 15/0/1", bus.change, bus.short_change, bus.vend_item); end
    tick();
    tick();
    pay(7'd5, 2);
    finish_disp();
    total++; if (bus.short_change !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL short_flag short=%b busy=%b want 1/0", bus.short_change, bus.busy); end
    total++; if (dut.u_inv.cnt_q[0] !== 8'd0 || bus.avail_coins !== 5'b10000 || bus.low_nickels !== 1'b1) begin bad++; $display("FAIL short_inv nickels=%0d avail=%b low=%b want 0/10000/1", dut.u_inv.cnt_q[0], bus.avail_coins, bus.low_nickels); end
  endtask

  task automatic test_priority();
    do_reset();
    insert(3'd2);
    bus.coin_valid = 1'b1;
    bus.coin_code  = 3'd0;
    bus.select     = 1'b1;
    bus.price      = 10'd25;
    tick();
    bus.coin_valid = 1'b0;
    bus.select     = 1'b0;
    total++; if (bus.vend_item !== 1'b1 || bus.coin_reject !== 1'b1) begin bad++; $display("FAIL prio_pulses vend=%b rej=%b want 1/1", bus.vend_item, bus.coin_reject); end
    total++; if (bus.credit !== 10'd0 || bus.go_signal !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL prio_state credit=%0d go=%b busy=%b want 0/0/0", bus.credit, bus.go_signal, bus.busy); end
    total++; if (dut.u_inv.cnt_q[0] !== 8'd10) begin bad++; $display("FAIL prio_inv got=%0d want=10", dut.u_inv.cnt_q[0]); end
  endtask

  task automatic test_refund();
    do_reset();
    insert(3'd2);
    insert(3'd1);
    bus.refund = 1'b1;
    tick();
    bus.refund = 1'b0;
`ifdef REFUND_EN
    total++; if (bus.change !== 10'd35 || bus.go_signal !== 1'b1) begin bad++; $display("FAIL refund_go change=%0d go=%b want 35/1", bus.change, bus.go_signal); end
    total++; if (bus.vend_item !== 1'b0 || bus.credit !== 10'd0) begin bad++; $display("FAIL refund_state vend=%b credit=%0d want 0/0", bus.vend_item, bus.credit); end
    tick();
    tick();
    pay(7'd25, 1);
    pay(7'd10, 1);
    finish_disp();
    total++; if (bus.short_change !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL refund_done short=%b busy=%b want 0/0", bus.short_change, bus.busy); end
`else
    total++; if (bus.credit !== 10'd35 || bus.go_signal !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL refund_off credit=%0d go=%b busy=%b want 35/0/0", bus.credit, bus.go_signal, bus.busy); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    insert(3'd4);
    select_price(10'd40);
    total++; if (bus.change !== 10'd60) begin bad++; $display("FAIL mid_change got=%0d want=60", bus.change); end
    tick();
    tick();
    pay(7'd50, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.change !== 10'd0 || bus.credit !== 10'd0 || bus.busy !== 1'b0 || bus.go_signal !== 1'b0 || bus.short_change !== 1'b0) begin bad++; $display("FAIL mid_outputs change=%0d credit=%0d busy=%b go=%b short=%b want all 0", bus.change, bus.credit, bus.busy, bus.go_signal, bus.short_change); end
    total++; if (bus.avail_coins !== 5'b11111 || dut.u_inv.cnt_q[3] !== 8'd10) begin bad++; $display("FAIL mid_inv avail=%b halves=%0d want 11111/10", bus.avail_coins, dut.u_inv.cnt_q[3]); end
  endtask

  task automatic test_ack_timeout();
    do_reset();
    insert(3'd2);
    select_price(10'd20);
    bus.disp_done = 1'b1;
    tick();
    bus.coin_valid = 1'b1;
    bus.coin_code  = 3'd4;
    tick();
    bus.coin_valid = 1'b0;
    total++; if (bus.coin_reject !== 1'b1 || bus.credit !== 10'd0) begin bad++; $display("FAIL busy_coin rej=%b credit=%0d want 1/0", bus.coin_reject, bus.credit); end
    tick();
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ack_wait busy=%b want 1", bus.busy); end
    tick();
    bus.disp_done = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.short_change !== 1'b1 || bus.change !== 10'd0) begin bad++; $display("FAIL ack_timeout busy=%b short=%b change=%0d want 0/1/0", bus.busy, bus.short_change, bus.change); end
  endtask

  initial begin
    test_reset();
    test_basic_vend();
    test_credit_ceiling();
    test_insufficient();
    test_short_change();
    test_priority();
    test_refund();
    test_reset_mid();
    test_ack_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction sequencer for the vending datapath: accepts coins, accumulates credit, handles item selection, and computes the change owed.
- Drives the change dispenser through its go/done handshake.
- Keeps the per-denomination coin inventory that feeds the dispenser's avail_coins and low_nickels inputs.
- Sits between the front-panel/coin-acceptor logic and change_dispenser.

Parameters:
- CNT_W, 8: width of each coin inventory counter.
- INIT_COUNT, 10: inventory value per denomination after reset.
- LOW_NICKEL_THRESH, 4: low_nickels asserted while nickel count < this value.
- MAX_CREDIT, 1000: credit ceiling in cents; must be <= 1023.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is high
- coin_valid  in  1  single-cycle pulse, coin inserted
- coin_code  in  3  0=5c, 1=10c, 2=25c, 3=50c, 4=100c; 5-7 invalid
- select  in  1  single-cycle pulse, item requested
- price  in  10  item price in cents, sampled with select
- refund  in  1  single-cycle pulse, return credit (REFUND_EN only)
- disp_done  in  1  change_dispenser done
- change_dispensed  in  7  change_dispenser coin output (0/5/10/25/50/100)
- go_signal  out  1  one-cycle start to dispenser
- change  out  10  amount to dispense, held stable from go until done rises
- avail_coins  out  5  bit i = inventory[i] != 0
- low_nickels  out  1  nickel inventory < LOW_NICKEL_THRESH
- credit  out  10  current credit
- vend_item  out  1  one-cycle pulse, item released
- coin_reject  out  1  one-cycle pulse, coin not accepted
- insufficient  out  1  one-cycle pulse, select with credit < price
- short_change  out  1  sticky until the next select; last dispense paid less than change
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; inventory = INIT_COUNT each; state IDLE; avail_coins = 5'b11111 and low_nickels = (INIT_COUNT < LOW_NICKEL_THRESH) on the cycle after reset.
- avail_coins and low_nickels are combinational from the inventory registers.
- States: IDLE, GO, WAIT_ACK, WAIT_DONE.
- IDLE, coin handling:
  - A coin_valid with a valid code is accepted only if credit + value <= MAX_CREDIT.
  - On accept: credit += value; inventory[code] += 1, saturating at 2^CNT_W-1 (the coin is still accepted).
  - Otherwise: coin_reject pulses the next cycle; credit and inventory unchanged.
- IDLE, select handling:
  - If credit >= price: vend_item pulses and credit -> 0. If credit - price == 0, stay in IDLE. Otherwise latch change = credit - price, clear the dispensed accumulator, and go to GO.
  - If credit < price: insufficient pulses; no other change.
- GO: go_signal = 1 for exactly this cycle, then WAIT_ACK.
- WAIT_ACK: wait for disp_done == 0, then WAIT_DONE. If disp_done stays high 4 cycles, treat the dispense as complete with 0 paid: short_change = 1, go to IDLE.
- WAIT_DONE:
  - Every cycle change_dispensed != 0: decrement that denomination's inventory (floor 0) and add the value to a 10-bit paid accumulator.
  - On disp_done == 1: short_change = (paid != change), then IDLE. change returns to 0 on entering IDLE.
- Priority in IDLE, same cycle:
  - refund > select > coin.
  - The losing coin gets coin_reject; the losing select is dropped silently.
- coin_valid while busy -> coin_reject. select and refund while busy are ignored.
- Reset mid-transaction aborts immediately to reset values. The dispenser shares the reset.

Optional Feature:
- Macro REFUND_EN.
- Defined, refund in IDLE with credit != 0: change = credit, credit -> 0, no vend_item, enter GO. With credit == 0, ignored.
- Undefined: the refund port exists but is ignored; refund logic is not built.

Decomposition:
- Package vend_pkg holds:
  - the coin_code localparams and their cent-value lookup function;
  - the state enum;
  - the denomination count (5).
- One natural sub-module: coin_inventory. It holds 5 saturating up/down counters with inc/dec ports and produces avail_coins and low_nickels.

Test Plan:
- Insert 100c, 25c, then select price 75 -> vend_item pulse; go_signal one cycle with change = 50; dispenser pays 50; short_change = 0; dollar inventory 11, quarter inventory 11, half inventory 9.
- Credit 995, insert 10c -> coin_reject pulse; credit stays 995; dime inventory unchanged.
- Credit 50, select price 60 -> insufficient pulse; credit 50; go_signal never asserted.
- Reset with INIT_COUNT 0 except nickels 2; credit 100, select price 85 (change 15) -> avail_coins = 00001; low_nickels = 1; dispenser pays 10 of 15; short_change = 1; nickel inventory 0.
- coin_valid and select on the same cycle in IDLE (credit 25, price 25) -> vend_item pulse; coin_reject pulse; credit 0; no go_signal.
- REFUND_EN defined, credit 35, refund -> change = 35; go_signal pulse; no vend_item; credit 0. Reset asserted in WAIT_DONE -> all outputs 0 next cycle.
